dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 41 ++++
 rtl/wlog_fifo.sv | 54 +++++
 rtl/dmem_responder.sv | 130 +++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and store-lane helpers for the data-memory responder.
package dmem_pkg;

  localparam logic [1:0] MW_NONE  = 2'b00;
  localparam logic [1:0] MW_WORD  = 2'b01;
  localparam logic [1:0] MW_DWORD = 2'b10;
  localparam logic [1:0] MW_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PASS = 2'd1,
    FAIL = 2'd2
  } state_e;

  // Word stores only replace the 32-bit lane picked by address bit 2.
  function automatic logic [63:0] store_merge(input logic [63:0] old_word,
                                              input logic [1:0]  mw,
                                              input logic        lane_hi,
                                              input logic [63:0] wdata);
    logic [63:0] merged;
    case (mw)
      MW_WORD:  merged = lane_hi ? {wdata[31:0], old_word[31:0]}
                                 : {old_word[63:32], wdata[31:0]};
      MW_DWORD: merged = wdata;
      default:  merged = old_word;
    endcase
    return merged;
  endfunction

  function automatic logic [63:0] log_value(input logic [1:0]  mw,
                                            input logic [63:0] wdata);
    logic [63:0] val;
    case (mw)
      MW_WORD:  val = {32'd0, wdata[31:0]};
      MW_DWORD: val = wdata;
      default:  val = 64'd0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/wlog_fifo.sv
// Write-log FIFO; a push into a full FIFO is dropped unless a pop happens in the same cycle.
module wlog_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_ovf
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW:0]      r_wr_ptr;
  logic [PW:0]      r_rd_ptr;
  logic             r_ovf;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;

  // The extra pointer bit separates full from empty when the indices match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                   (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign w_pop   = i_pop && !w_empty;
  assign w_push  = i_push && (!w_full || w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (i_push && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[PW-1:0]] <= i_data;
  end

  assign o_valid = !w_empty;
  assign o_data  = r_mem[r_rd_ptr[PW-1:0]];
  assign o_ovf   = r_ovf;

endmodule

// File: rtl/dmem_responder.sv
// Doubleword data memory with a store log and a RUN/PASS/FAIL status monitor
// keyed on a store signature and a cycle budget.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH     = 64,
  parameter int LOGDEPTH  = 8,
  parameter int TIMEOUT   = 1300,
  parameter int PASS_ADR  = 100,
  parameter int PASS_DATA = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] dataadr,
  input  logic [63:0] writedata,
  input  logic [1:0]  memwrite,
  output logic [63:0] readdata,
  output logic        log_valid,
  input  logic        log_ready,
  output logic [63:0] log_adr,
  output logic [63:0] log_data,
  output logic        log_ovf,
  output logic        err,
  output logic        done,
  output logic        pass,
  output logic [31:0] cycles
);

  localparam int          IDX_W = $clog2(DEPTH);
  localparam logic [63:0] SPAN  = 64'(DEPTH) * 64'd8;

  logic [63:0]      r_mem [DEPTH];
  logic [63:0]      r_readdata;
  logic [31:0]      r_cycles;
  logic             r_err;
  logic             r_done;
  logic             r_pass;
  state_e           r_state;
  state_e           w_state_nxt;
  logic [IDX_W-1:0] w_idx;
  logic             w_in_range;
  logic             w_is_store;
  logic             w_accept;
  logic             w_bad;
  logic             w_pass_hit;
  logic [63:0]      w_log_val;
  logic [63:0]      w_new_word;
  logic [127:0]     w_log_head;

  assign w_idx      = dataadr[3 +: IDX_W];
  assign w_in_range = (dataadr < SPAN);
  assign w_is_store = (memwrite == MW_WORD) || (memwrite == MW_DWORD);
  assign w_accept   = w_is_store && w_in_range;
  assign w_bad      = (memwrite == MW_RSVD) || (w_is_store && !w_in_range);
  assign w_log_val  = log_value(memwrite, writedata);
  assign w_new_word = store_merge(r_mem[w_idx], memwrite, dataadr[2], writedata);
  assign w_pass_hit = w_accept && (dataadr == 64'(PASS_ADR)) &&
                      (w_log_val == 64'(PASS_DATA));

  // Memory array carries no reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[w_idx] <= w_new_word;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_readdata <= 64'd0;
      r_err      <= 1'b0;
    end else begin
      r_readdata <= w_in_range ? r_mem[w_idx] : 64'd0;
      if (w_bad) r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= RUN;
      r_cycles <= 32'd0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (w_state_nxt != RUN);
      r_pass  <= (w_state_nxt == PASS);
      if ((r_state == RUN) && (w_state_nxt == RUN)) r_cycles <= r_cycles + 32'd1;
    end
  end

  // A pass signature wins over the budget expiring in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN: begin
        if (w_pass_hit) begin
          w_state_nxt = PASS;
        end else if (r_cycles == 32'(TIMEOUT - 1)) begin
          w_state_nxt = FAIL;
        end else begin
          w_state_nxt = RUN;
        end
      end
      PASS:    w_state_nxt = PASS;
      FAIL:    w_state_nxt = FAIL;
      default: w_state_nxt = FAIL;
    endcase
  end

  wlog_fifo #(
    .WIDTH (128),
    .DEPTH (LOGDEPTH)
  ) u_wlog (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_push  (w_accept),
    .i_data  ({dataadr, w_log_val}),
    .i_pop   (log_ready),
    .o_valid (log_valid),
    .o_data  (w_log_head),
    .o_ovf   (log_ovf)
  );

  assign log_adr  = w_log_head[127:64];
  assign log_data = w_log_head[63:0];
  assign readdata = r_readdata;
  assign err      = r_err;
  assign done     = r_done;
  assign pass     = r_pass;
  assign cycles   = r_cycles;

endmodule
